// File: rtl/pcpu_ctrl_pkg.sv
// pcpu_ctrl_pkg
//   Shared encodings for the front-panel control path.
//   - exec_state_t : step executor states. These values also drive the panel
//                    LEDs, so they must stay fixed.
//   - panel_mode_t : panel controller modes, shared with the display decode.
package pcpu_ctrl_pkg;

  typedef enum logic [1:0] {
    EXEC_IDLE   = 2'b00,
    EXEC_STEP   = 2'b01,
    EXEC_RUN    = 2'b10,
    EXEC_HALTED = 2'b11
  } exec_state_t;

  typedef enum logic [1:0] {
    PANEL_STOP = 2'b00,
    PANEL_INC  = 2'b01,
    PANEL_TRAP = 2'b10
  } panel_mode_t;

  localparam int EXEC_STATE_W = 2;

endpackage

// File: rtl/pcpu_step_executor.sv
// pcpu_step_executor
//   Turns the panel's one-cycle sense pulse into a burst of max(steps,1) CPU
//   clock-enable cycles. It also supports a free-run level mode and latches
//   CPU halt until reset.
// Ports
//   myclk     : system clock, rising edge
//   reset     : asynchronous, active-high
//   sense     : single-cycle step request (accepted only in IDLE)
//   run       : free-run level request
//   steps     : burst length, sampled when sense is accepted (0 means 1)
//   halt      : CPU halt level
//   cpu_en    : CPU global enable (STEP or RUN)
//   busy      : step burst in progress
//   halted    : halt captured (sticky)
//   state_dbg : raw state encoding for the LEDs
//   cycle_cnt : count of enabled cycles, wraps
module pcpu_step_executor
  import pcpu_ctrl_pkg::*;
#(
  parameter int STEP_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              myclk,
  input  logic              reset,
  input  logic              sense,
  input  logic              run,
  input  logic [STEP_W-1:0] steps,
  input  logic              halt,
  output logic              cpu_en,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        state_dbg,
  output logic [CNT_W-1:0]  cycle_cnt
);

  exec_state_t       state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge myclk or posedge reset) begin
    if (reset) begin
      state_q <= EXEC_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      EXEC_IDLE: begin
        if (halt)       state_d = EXEC_HALTED;
        else if (run)   state_d = EXEC_RUN;
        else if (sense) begin
          state_d = EXEC_STEP;
          rem_d   = (steps == '0) ? STEP_W'(1) : steps;
        end
      end
      EXEC_STEP: begin
        // sense/run are not queued; a new burst needs a fresh pulse in IDLE
        if (halt) state_d = EXEC_HALTED;
        else if (rem_q == STEP_W'(1)) begin
          state_d = EXEC_IDLE;
          rem_d   = '0;
        end else rem_d = rem_q - STEP_W'(1);
      end
      EXEC_RUN: begin
        if (halt)      state_d = EXEC_HALTED;
        else if (!run) state_d = EXEC_IDLE;
      end
      default: state_d = EXEC_HALTED; // sticky until reset
    endcase
  end

  // Count uses the registered enable, so the cycle that ends on a halt edge
  // is still counted.
  always_ff @(posedge myclk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (cpu_en) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cpu_en    = (state_q == EXEC_STEP) || (state_q == EXEC_RUN);
  assign busy      = (state_q == EXEC_STEP);
  assign halted    = (state_q == EXEC_HALTED);
  assign state_dbg = state_q;
  assign cycle_cnt = cnt_q;

endmodule
